// File: rtl/prog_launcher_if.sv
// Start/Ack handshake and status bundle between the program launcher and the test harness.
// master: launcher side; slave: harness/processor side.
interface prog_launcher_if #(
  parameter int PW = 2
) ();
  logic          Go;
  logic          Ack;
  logic          Start;
  logic [PW-1:0] ProgNum;
  logic          Busy;
  logic [15:0]   CycleCt;
  logic          CycleValid;
  logic          AllDone;
  logic          TimedOut;

  modport master (
    input  Go, Ack,
    output Start, ProgNum, Busy, CycleCt, CycleValid, AllDone, TimedOut
  );

  modport slave (
    output Go, Ack,
    input  Start, ProgNum, Busy, CycleCt, CycleValid, AllDone, TimedOut
  );
endinterface

// File: rtl/prog_launcher.sv
// Launches NUM_PROGS programs back-to-back over the Start/Ack handshake,
// measuring each program's Ack-low cycle count and aborting a hung program on timeout.
module prog_launcher #(
  parameter int          NUM_PROGS = 3,
  parameter int          PW        = 2,
  parameter int          START_LEN = 2,
  parameter logic [15:0] TIMEOUT   = 16'hFFFE
) (
  input logic             Clk,
  input logic             Reset,
  prog_launcher_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_CLR,
    RUN,
    REPORT,
    ABORT
  } state_t;

  localparam logic [PW-1:0] LAST_PROG   = PW'(NUM_PROGS - 1);
  localparam logic [15:0]   LAUNCH_LAST = 16'(START_LEN - 1);

  state_t        r_state;
  logic [15:0]   r_launch_ct;
  logic [15:0]   r_wait_ct;
  logic [15:0]   r_run_ct;
  logic          r_start;
  logic [PW-1:0] r_prog;
  logic          r_busy;
  logic [15:0]   r_cycle_ct;
  logic          r_cycle_valid;
  logic          r_all_done;
  logic          r_timed_out;

  // Wait and run counters are loaded with 1 on entry so that a value equal to
  // TIMEOUT means TIMEOUT cycles have been spent in the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_launch_ct   <= '0;
      r_wait_ct     <= '0;
      r_run_ct      <= '0;
      r_start       <= 1'b0;
      r_prog        <= '0;
      r_busy        <= 1'b0;
      r_cycle_ct    <= '0;
      r_cycle_valid <= 1'b0;
      r_all_done    <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      r_cycle_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Go) begin
            r_state     <= LAUNCH;
            r_prog      <= '0;
            r_all_done  <= 1'b0;
            r_timed_out <= 1'b0;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
            r_launch_ct <= '0;
          end
        end
        LAUNCH: begin
          if (r_launch_ct == LAUNCH_LAST) begin
            r_state   <= WAIT_CLR;
            r_start   <= 1'b0;
            r_wait_ct <= 16'd1;
          end else begin
            r_launch_ct <= r_launch_ct + 16'd1;
          end
        end
        WAIT_CLR: begin
          if (!bus.Ack) begin
            r_state  <= RUN;
            r_run_ct <= 16'd1;
          end else if (r_wait_ct == TIMEOUT) begin
            r_state <= ABORT;
          end else begin
            r_wait_ct <= r_wait_ct + 16'd1;
          end
        end
        RUN: begin
          if (bus.Ack) begin
            r_cycle_ct    <= r_run_ct;
            r_cycle_valid <= 1'b1;
            r_state       <= REPORT;
          end else if (r_run_ct == TIMEOUT) begin
            r_state <= ABORT;
          end else begin
            r_run_ct <= r_run_ct + 16'd1;
          end
        end
        REPORT: begin
          if (r_prog == LAST_PROG) begin
            r_all_done <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_prog      <= r_prog + 1'b1;
            r_start     <= 1'b1;
            r_launch_ct <= '0;
            r_state     <= LAUNCH;
          end
        end
        ABORT: begin
          r_timed_out <= 1'b1;
          r_all_done  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Start      = r_start;
  assign bus.ProgNum    = r_prog;
  assign bus.Busy       = r_busy;
  assign bus.CycleCt    = r_cycle_ct;
  assign bus.CycleValid = r_cycle_valid;
  assign bus.AllDone    = r_all_done;
  assign bus.TimedOut   = r_timed_out;

endmodule

// File: tb/tb_prog_launcher.sv
// Bench for prog_launcher: a processor model drives Ack, and a sequence-level
// model predicts per-program counts, abort point and final status.
module tb_prog_launcher;
  localparam int NP = 3;
  localparam int SL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic ack = 1'b1;
  bit   sel = 1'b0;

  always #5 clk = ~clk;

  prog_launcher_if #(.PW(2)) ifa ();
  prog_launcher_if #(.PW(2)) ifb ();

  assign ifa.Go  = (sel == 1'b0) ? go  : 1'b0;
  assign ifa.Ack = (sel == 1'b0) ? ack : 1'b1;
  assign ifb.Go  = (sel == 1'b1) ? go  : 1'b0;
  assign ifb.Ack = (sel == 1'b1) ? ack : 1'b1;

  prog_launcher #(.NUM_PROGS(3), .PW(2), .START_LEN(2), .TIMEOUT(16'hFFFE)) dut_a (
    .Clk(clk), .Reset(rst), .bus(ifa.master)
  );
  prog_launcher #(.NUM_PROGS(3), .PW(2), .START_LEN(2), .TIMEOUT(16'd8)) dut_b (
    .Clk(clk), .Reset(rst), .bus(ifb.master)
  );

  logic        start, busy, cv, ad, tmo_o;
  logic [1:0]  pn;
  logic [15:0] ct;
  assign start = sel ? ifb.Start      : ifa.Start;
  assign busy  = sel ? ifb.Busy       : ifa.Busy;
  assign cv    = sel ? ifb.CycleValid : ifa.CycleValid;
  assign ad    = sel ? ifb.AllDone    : ifa.AllDone;
  assign tmo_o = sel ? ifb.TimedOut   : ifa.TimedOut;
  assign pn    = sel ? ifb.ProgNum    : ifa.ProgNum;
  assign ct    = sel ? ifb.CycleCt    : ifa.CycleCt;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Event recorder: CycleValid reports and Start pulse lengths
  int q_ct[$];
  int q_pn[$];
  int q_sl[$];
  int slen = 0;
  always @(negedge clk) begin
    if (cv) begin
      q_ct.push_back(int'(ct));
      q_pn.push_back(int'(pn));
    end
    if (!start && slen > 0) q_sl.push_back(slen);
    slen <= start ? slen + 1 : 0;
  end

  int sd[NP];
  int sn[NP];
  int last_ct[2];

  task automatic drive_seq(input bit pulse_go, input bit glitch, input bit gospam);
    int g;
    if (pulse_go) begin
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      chk("go_clears_alldone", int'(ad), 0);
      chk("go_clears_timedout", int'(tmo_o), 0);
      chk("go_prognum0", int'(pn), 0);
      chk("go_busy", int'(busy), 1);
    end
    for (int p = 0; p < NP; p++) begin
      g = 0;
      while (!start && busy && g < 40) begin @(negedge clk); g++; end
      if (!busy) break;
      if (!start) begin chk("start_wait", 0, 1); break; end
      g = 0;
      while (start && g < 20) begin
        ack = glitch ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        g++;
      end
      ack = 1'b1;
      repeat (sd[p]) @(negedge clk);
      ack = 1'b0;
      if (gospam) go = 1'b1;
      repeat (sn[p]) @(negedge clk);
      ack = 1'b1;
      if (gospam) go = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 400) begin @(negedge clk); g++; end
    if (busy) chk("idle_wait", 0, 1);
  endtask

  // Sequence-level prediction: each program either completes with count = Ack-low
  // length, or aborts when Ack-high wait reaches the timeout or Ack-low exceeds it.
  task automatic check_seq(input string tag, input bit have_tab, input bit t_to,
                           input int t_pn, input int t_ct, input int b_ct, input int b_sl);
    int tmo = sel ? 8 : 65534;
    int L = 0;
    int epn = 0;
    bit eto = 1'b0;
    int ect[$];
    int nact;
    for (int p = 0; p < NP; p++) begin
      L = p + 1;
      epn = p;
      if (sd[p] >= tmo || sn[p] > tmo) begin eto = 1'b1; break; end
      ect.push_back(sn[p]);
    end
    if (ect.size() > 0) last_ct[sel] = ect[$];
    nact = q_ct.size() - b_ct;
    chk({tag, "_nvalid"}, nact, ect.size());
    for (int i = 0; i < ect.size(); i++) begin
      if (i < nact) begin
        chk({tag, "_cyclect"}, q_ct[b_ct + i], ect[i]);
        chk({tag, "_valid_prognum"}, q_pn[b_ct + i], i);
      end
    end
    chk({tag, "_nstart"}, q_sl.size() - b_sl, L);
    for (int i = b_sl; i < q_sl.size(); i++) chk({tag, "_startlen"}, q_sl[i], SL);
    chk({tag, "_alldone"}, int'(ad), 1);
    chk({tag, "_timedout"}, int'(tmo_o), int'(eto));
    chk({tag, "_prognum"}, int'(pn), epn);
    chk({tag, "_cyclect_hold"}, int'(ct), last_ct[sel]);
    if (have_tab) begin
      chk({tag, "_tab_timedout"}, int'(tmo_o), int'(t_to));
      chk({tag, "_tab_prognum"}, int'(pn), t_pn);
      chk({tag, "_tab_cyclect"}, int'(ct), t_ct);
    end
  endtask

  typedef struct {
    bit sel;
    int d0, d1, d2;
    int n0, n1, n2;
    bit glitch;
    bit to;
    int pn;
    int ct;
  } vec_t;

  vec_t tab[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int b_ct, b_sl, c, g;
    last_ct[0] = 0;
    last_ct[1] = 0;

    tab[0] = '{1'b0, 1, 1, 1, 10, 10, 10, 1'b0, 1'b0, 2, 10};
    tab[1] = '{1'b0, 1, 0, 2, 10,  5,  1, 1'b1, 1'b0, 2,  1};
    tab[2] = '{1'b1, 99, 0, 0,  5,  5,  5, 1'b0, 1'b1, 0,  0};
    tab[3] = '{1'b1, 7, 0, 3,   8,  1,  2, 1'b1, 1'b0, 2,  2};
    tab[4] = '{1'b1, 0, 2, 0,   3, 99,  4, 1'b0, 1'b1, 1,  3};
    tab[5] = '{1'b1, 8, 0, 0,   1,  1,  1, 1'b0, 1'b1, 0,  3};
    tab[6] = '{1'b1, 0, 0, 0,   9,  1,  1, 1'b0, 1'b1, 0,  3};
    tab[7] = '{1'b1, 0, 0, 0,   1,  8,  6, 1'b1, 1'b0, 2,  6};

    #3;
    chk("rst_start", int'(ifa.Start), 0);
    chk("rst_busy", int'(ifa.Busy), 0);
    chk("rst_cyclect", int'(ifa.CycleCt), 0);
    chk("rst_alldone", int'(ifa.AllDone), 0);
    chk("rst_timedout", int'(ifb.TimedOut), 0);
    chk("rst_prognum", int'(ifb.ProgNum), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      sel = tab[v].sel;
      sd[0] = tab[v].d0; sd[1] = tab[v].d1; sd[2] = tab[v].d2;
      sn[0] = tab[v].n0; sn[1] = tab[v].n1; sn[2] = tab[v].n2;
      b_ct = q_ct.size(); b_sl = q_sl.size();
      drive_seq(1'b1, tab[v].glitch, 1'b0);
      wait_idle();
      check_seq($sformatf("tab%0d", v), 1'b1, tab[v].to, tab[v].pn, tab[v].ct, b_ct, b_sl);
    end

    // Go pulsed repeatedly while busy: no effect, no restart afterwards
    sel = 1'b0;
    sd = '{0, 0, 0}; sn = '{4, 6, 3};
    b_ct = q_ct.size(); b_sl = q_sl.size();
    drive_seq(1'b1, 1'b0, 1'b1);
    wait_idle();
    check_seq("gobusy", 1'b0, 1'b0, 0, 0, b_ct, b_sl);
    repeat (3) @(negedge clk);
    chk("gobusy_no_restart", int'(busy), 0);
    chk("gobusy_no_start", q_sl.size() - b_sl, 3);

    // Go held high through completion: one IDLE cycle, then a fresh sequence
    sd = '{1, 1, 1}; sn = '{2, 3, 4};
    go = 1'b1;
    @(negedge clk);
    drive_seq(1'b0, 1'b0, 1'b0);
    g = 0;
    while (busy && g < 50) begin @(negedge clk); g++; end
    chk("hold_done_alldone", int'(ad), 1);
    chk("hold_done_prognum", int'(pn), 2);
    chk("hold_done_cyclect", int'(ct), 4);
    last_ct[0] = 4;
    c = 0;
    while (!busy && c < 10) begin @(negedge clk); c++; end
    chk("hold_idle_cycles", c, 1);
    chk("hold_restart_start", int'(start), 1);
    chk("hold_restart_prognum", int'(pn), 0);
    chk("hold_restart_alldone", int'(ad), 0);
    go = 1'b0;
    sd = '{0, 0, 0}; sn = '{7, 2, 5};
    b_ct = q_ct.size(); b_sl = q_sl.size();
    drive_seq(1'b0, 1'b0, 1'b0);
    wait_idle();
    check_seq("hold2", 1'b0, 1'b0, 0, 0, b_ct, b_sl);

    // Randomized sequences against the model
    for (int r = 0; r < 24; r++) begin
      sel = (r % 3 == 0) ? 1'b0 : 1'b1;
      for (int p = 0; p < NP; p++) begin
        sd[p] = sel ? $urandom_range(0, 8) : $urandom_range(0, 4);
        sn[p] = sel ? $urandom_range(1, 9) : $urandom_range(1, 30);
      end
      b_ct = q_ct.size(); b_sl = q_sl.size();
      drive_seq(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      wait_idle();
      check_seq($sformatf("rnd%0d", r), 1'b0, 1'b0, 0, 0, b_ct, b_sl);
    end

    // Asynchronous reset while Start is high
    sel = 1'b0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("pre_rst_start", int'(start), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_start", int'(start), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_cyclect", int'(ct), 0);
    chk("async_rst_alldone", int'(ad), 0);
    chk("async_rst_prognum", int'(pn), 0);
    @(negedge clk); rst = 1'b0;
    last_ct[0] = 0;
    last_ct[1] = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle_busy", int'(busy), 0);
    chk("post_rst_idle_start", int'(start), 0);
    sd = '{0, 0, 0}; sn = '{1, 2, 3};
    b_ct = q_ct.size(); b_sl = q_sl.size();
    drive_seq(1'b1, 1'b0, 1'b0);
    wait_idle();
    check_seq("post_rst", 1'b0, 1'b0, 0, 0, b_ct, b_sl);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
